dcache_nway: RTL and testbench
==============================

Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate data cache; successor to the fixed 8-set, 2-way, 2-word dcache.
- Sits between datapath memory-stage request signals and the memory controller's per-CPU data channel.
- Set count, associativity and block size are configurable; replacement is true LRU.
- On halt, flushes every dirty block, then optionally writes the hit count to memory.

Parameters:
CPUID, 0, index of this CPU on the shared controller (carried for instantiation; ports are flat)
SETS, 8, number of sets; power of two, >= 2
WAYS, 2, associativity; power of two, 1..8
BLKWORDS, 2, 32-bit words per block; power of two, 1..8

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
halt  in  1  datapath halt; level-sensitive, starts flush
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request (never asserted together with dmemREN)
dmemaddr  in  32  byte address, word aligned
dmemstore  in  32  write data
dhit  out  1  request complete this cycle
dmemload  out  32  read data, valid while dhit=1
flushed  out  1  flush complete
dwait  in  1  controller busy; a beat completes on a cycle with dwait=0
dload  in  32  memory read data
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data

Behaviour:
- Clock is CLK. Reset nRST is asynchronous, active-low. While nRST=0, all valid, dirty and LRU-age bits clear, all counters clear, state=IDLE, and every output is 0.
- Address split, LSB upward: 2 bits byte offset, log2(BLKWORDS) bits word offset, log2(SETS) bits index, remaining bits tag.
- Hit: in IDLE, some way in the indexed set is valid with a matching tag. dhit=1 in the same cycle (combinational).
  - Read hit: dmemload = selected word.
  - Write hit: store the word and set dirty at the next edge.
- LRU: each way holds a log2(WAYS)-bit age. On any hit, the accessed way's age becomes 0; ways younger than it increment by 1.
- Victim selection: the lowest-numbered invalid way; otherwise the way with age WAYS-1. The victim is latched on leaving IDLE.
- States:
  - IDLE: halt has priority and goes to FLUSH_CHK. Otherwise, a miss goes to WB if the victim is dirty, else to FETCH. With no request, stay in IDLE.
  - WB: dWEN=1; daddr = {victim tag, index, word counter, 2'b00}; dstore = the corresponding word. The word counter increments on each dwait=0 beat. After beat BLKWORDS-1, clear dirty and go to FETCH.
  - FETCH: dREN=1; daddr = {request tag, index, word counter, 2'b00}. On each dwait=0 beat, write dload into the victim's word. After the last beat, set valid, write the tag and go to IDLE. The pending request then hits on the next cycle.
  - FLUSH_CHK: scan pointer runs over (way, set), set fastest. A dirty block goes to FLUSH_WB; otherwise the pointer increments. After the last block, go to CNT_WR when HITCOUNT_EN is defined, else to FLUSHED.
  - FLUSH_WB: writes the block word by word, as in WB, using the block's stored tag. After the last beat, clear dirty, increment the pointer and return to FLUSH_CHK.
  - CNT_WR: described under Optional Feature.
  - FLUSHED: flushed=1; dhit=0; stays here until reset.
- Hit counter (32-bit, saturating): increments on an IDLE hit only when no refill occurred for that request. A "refilled" flag is set on FETCH exit and cleared on the next dhit.
- dREN and dWEN are never both 1. Both are 0 in IDLE and FLUSHED.
- Request inputs are ignored outside IDLE.
- Reset mid-burst: abandon the burst immediately; the cache returns to all-invalid.

Optional Feature:
HITCOUNT_EN
- Defined:
  - CNT_WR state: dWEN=1, daddr=32'h00003100, dstore=hit counter.
  - Holds until a dwait=0 beat, then goes to FLUSHED.
- Undefined:
  - No CNT_WR state and no hit counter.
  - FLUSH_CHK goes directly to FLUSHED after the last block.

Test Plan:
- Cold read 0x80 (SETS=8, WAYS=2, BLKWORDS=2), memory returns 0xAAAA0000 and 0xAAAA0001 with dwait=0 per beat -> FETCH daddr 0x80, 0x84. dhit=1 with dmemload=0xAAAA0000 on the first cycle back in IDLE.
- Write 0xDEADBEEF to 0x84 after the above -> same-cycle dhit, no memory traffic. A following read of 0x84 returns 0xDEADBEEF.
- Touch tags at 0x80, 0x180, then 0x80, then miss at 0x280 -> 0x180's way is evicted. The writeback occurs only if that block is dirty.
- Dirty victim with dwait held 1 for 3 cycles per beat -> dWEN and daddr stay stable while dwait=1. Two write beats precede the two read beats.
- halt with 3 dirty blocks -> exactly 6 write beats in scan order, then (HITCOUNT_EN) a write of the hit count to 0x3100. flushed=1 and held.
- Deassert nRST during the second FETCH beat -> all outputs 0 asynchronously. After release, the same address misses again.

Source files
------------

// File: rtl/dcache_nway.sv
// Parametrised write-back, write-allocate, true-LRU data cache.
// Define HITCOUNT_EN to add the hit counter and its write-out after flush.
module dcache_nway #(
    parameter int CPUID    = 0,
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);
    localparam int OB = $clog2(BLKWORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - OB - IB;
    localparam int OW = (OB > 0) ? OB : 1;
    localparam int WI = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW = $clog2(WAYS * SETS) + 1;
    localparam logic [WI-1:0] AMAX = WI'(WAYS - 1);

    if (SETS < 2 || WAYS < 1 || WAYS > 8 || BLKWORDS < 1 || BLKWORDS > 8 || CPUID < 0) begin : g_bad_cfg
        $error("dcache_nway: unsupported parameters");
    end

    typedef enum logic [2:0] {
        IDLE, WB, FETCH, FLUSH_CHK, FLUSH_WB,
`ifdef HITCOUNT_EN
        CNT_WR,
`endif
        FLUSHED
    } state_t;

    state_t state_q, state_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic [WI-1:0] vic_q, vic_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TB+IB-1:0] req_q;

    logic [31:0]   data_q  [WAYS][SETS][BLKWORDS];
    logic [TB-1:0] tag_q   [WAYS][SETS];
    logic          valid_q [WAYS][SETS];
    logic          dirty_q [WAYS][SETS];
    logic [WI-1:0] age_q   [WAYS][SETS];
`ifdef HITCOUNT_EN
    logic [31:0] hitcnt_q;
    logic        refilled_q;
`endif

    logic [IB-1:0] in_idx, r_idx, f_set;
    logic [TB-1:0] in_tag, r_tag;
    logic [OW-1:0] in_off;
    logic [WI-1:0] hit_way, vic_sel, f_way, best, hit_age;
    logic hit_any, found, req, miss_go;
    logic fill_beat, fill_done, wb_done, fwb_done;
    logic unused_bits;

    assign in_idx = dmemaddr[2+OB +: IB];
    assign in_tag = dmemaddr[31 -: TB];
    assign in_off = (OB == 0) ? '0 : OW'(dmemaddr >> 2);
    assign r_idx  = req_q[IB-1:0];
    assign r_tag  = req_q[TB+IB-1 -: TB];
    assign f_set  = IB'(ptr_q);
    assign f_way  = WI'(ptr_q >> IB);
    assign unused_bits = ^dmemaddr[1:0];

    function automatic logic [31:0] mkaddr(input logic [TB-1:0] t,
                                           input logic [IB-1:0] s,
                                           input logic [OW-1:0] o);
        mkaddr = (32'({t, s}) << (2 + OB)) | ((OB == 0) ? 32'd0 : (32'(o) << 2));
    endfunction

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        found   = 1'b0;
        vic_sel = '0;
        best    = age_q[0][in_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][in_idx] && tag_q[w][in_idx] == in_tag) begin
                hit_any = 1'b1;
                hit_way = WI'(w);
            end
            if (!found && !valid_q[w][in_idx]) begin
                found   = 1'b1;
                vic_sel = WI'(w);
            end
        end
        // oldest way wins; lowest index breaks ties left over from reset
        if (!found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[w][in_idx] > best) begin
                    best    = age_q[w][in_idx];
                    vic_sel = WI'(w);
                end
            end
        end
        hit_age = age_q[hit_way][in_idx];
    end

    assign req      = (dmemREN | dmemWEN) & ~halt & (state_q == IDLE);
    assign dhit     = req & hit_any;
    assign dmemload = dhit ? data_q[hit_way][in_idx][in_off] : 32'd0;
    assign miss_go  = req & ~hit_any;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vic_d     = vic_q;
        ptr_d     = ptr_q;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = 32'd0;
        dstore    = 32'd0;
        flushed   = 1'b0;
        fill_beat = 1'b0;
        fill_done = 1'b0;
        wb_done   = 1'b0;
        fwb_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH_CHK;
                    ptr_d   = '0;
                end else if (miss_go) begin
                    vic_d   = vic_sel;
                    cnt_d   = '0;
                    state_d = dirty_q[vic_sel][in_idx] ? WB : FETCH;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = mkaddr(tag_q[vic_q][r_idx], r_idx, cnt_q);
                dstore = data_q[vic_q][r_idx][cnt_q];
                if (!dwait) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OW'(BLKWORDS - 1)) begin
                        cnt_d   = '0;
                        wb_done = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = mkaddr(r_tag, r_idx, cnt_q);
                if (!dwait) begin
                    fill_beat = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == OW'(BLKWORDS - 1)) begin
                        cnt_d     = '0;
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH_CHK: begin
                if (ptr_q == PW'(WAYS * SETS)) begin
`ifdef HITCOUNT_EN
                    state_d = CNT_WR;
`else
                    state_d = FLUSHED;
`endif
                end else if (dirty_q[f_way][f_set]) begin
                    cnt_d   = '0;
                    state_d = FLUSH_WB;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = mkaddr(tag_q[f_way][f_set], f_set, cnt_q);
                dstore = data_q[f_way][f_set][cnt_q];
                if (!dwait) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OW'(BLKWORDS - 1)) begin
                        cnt_d    = '0;
                        fwb_done = 1'b1;
                        ptr_d    = ptr_q + 1'b1;
                        state_d  = FLUSH_CHK;
                    end
                end
            end
`ifdef HITCOUNT_EN
            CNT_WR: begin
                dWEN   = 1'b1;
                daddr  = 32'h0000_3100;
                dstore = hitcnt_q;
                if (!dwait) state_d = FLUSHED;
            end
`endif
            FLUSHED: flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vic_q   <= '0;
            ptr_q   <= '0;
            req_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= '0;
                end
            end
`ifdef HITCOUNT_EN
            hitcnt_q   <= '0;
            refilled_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vic_q   <= vic_d;
            ptr_q   <= ptr_d;
            if (miss_go) req_q <= dmemaddr[31:2+OB];
            if (dhit) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WI'(w) == hit_way) begin
                        age_q[w][in_idx] <= '0;
                    end else if (age_q[w][in_idx] <= hit_age && age_q[w][in_idx] != AMAX) begin
                        age_q[w][in_idx] <= age_q[w][in_idx] + 1'b1;
                    end
                end
                if (dmemWEN) dirty_q[hit_way][in_idx] <= 1'b1;
            end
            if (wb_done)   dirty_q[vic_q][r_idx] <= 1'b0;
            if (fill_done) valid_q[vic_q][r_idx] <= 1'b1;
            if (fwb_done)  dirty_q[f_way][f_set] <= 1'b0;
`ifdef HITCOUNT_EN
            if (dhit) begin
                if (!refilled_q && hitcnt_q != '1) hitcnt_q <= hitcnt_q + 1'b1;
                refilled_q <= 1'b0;
            end
            if (fill_done) refilled_q <= 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN) data_q[hit_way][in_idx][in_off] <= dmemstore;
        if (fill_beat) data_q[vic_q][r_idx][cnt_q] <= dload;
        if (fill_done) tag_q[vic_q][r_idx] <= r_tag;
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (8 sets, 2 ways, 2-word blocks).
// A small memory responder supplies dwait/dload and logs every beat.
module tb_dcache_nway;
    logic        clk, nRST, halt, dmemREN, dmemWEN, dhit, flushed;
    logic        dwait, dREN, dWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload, dload, daddr, dstore;

    int tests = 0;
    int fails = 0;
    int lat = 0;
    int unstable = 0;
    int both = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;
    beat_t beats[$];
    logic [31:0] mem [logic [31:0]];

    dcache_nway #(.CPUID(0), .SETS(8), .WAYS(2), .BLKWORDS(2)) dut (
        .CLK(clk), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hF000_0000 | a;
    endfunction

    // memory side: decide dwait at negedge, beat completes on the next posedge
    initial begin
        int waitcnt;
        logic [31:0] held_a;
        logic held_w;
        waitcnt = 0;
        held_a = '0;
        held_w = 1'b0;
        dwait = 1'b1;
        dload = '0;
        forever begin
            @(negedge clk);
            if (dREN && dWEN) both++;
            if (dREN || dWEN) begin
                if (waitcnt == 0) begin
                    held_a = daddr;
                    held_w = dWEN;
                end else if (daddr !== held_a || dWEN !== held_w) begin
                    unstable++;
                end
                if (waitcnt < lat) begin
                    dwait = 1'b1;
                    waitcnt++;
                end else begin
                    dwait = 1'b0;
                    waitcnt = 0;
                    dload = rd(daddr);
                    if (dWEN) mem[daddr] = dstore;
                    beats.push_back('{dWEN, daddr, dWEN ? dstore : dload});
                end
            end else begin
                dwait = 1'b1;
                waitcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b = '{1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx};
        if (i < beats.size()) b = beats[i];
        check($sformatf("beat%0d_we", i), {31'd0, b.we}, {31'd0, we});
        check($sformatf("beat%0d_addr", i), b.a, a);
        check($sformatf("beat%0d_data", i), b.d, d);
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] ld, output int cyc);
        @(posedge clk);
        #1;
        dmemREN = r;
        dmemWEN = w;
        dmemaddr = a;
        dmemstore = d;
        cyc = 0;
        #1;
        while (!dhit && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        ld = dmemload;
        @(posedge clk);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    initial begin
        logic [31:0] ld;
        int cyc;
        int n;
        nRST = 1'b0;
        halt = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        dmemaddr = '0;
        dmemstore = '0;
        mem[32'h80] = 32'hAAAA_0000;
        mem[32'h84] = 32'hAAAA_0001;

        #12;
        check("rst_dhit", {31'd0, dhit}, 32'd0);
        check("rst_dREN", {31'd0, dREN}, 32'd0);
        check("rst_dWEN", {31'd0, dWEN}, 32'd0);
        check("rst_flushed", {31'd0, flushed}, 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        @(posedge clk);
        #1;
        nRST = 1'b1;

        // cold read miss
        beats.delete();
        access(1'b1, 1'b0, 32'h80, 32'd0, ld, cyc);
        check("cold_load", ld, 32'hAAAA_0000);
        check("cold_cycles", cyc, 32'd3);
        check("cold_nbeats", beats.size(), 32'd2);
        check_beat(0, 1'b0, 32'h80, 32'hAAAA_0000);
        check_beat(1, 1'b0, 32'h84, 32'hAAAA_0001);

        // write hit then read back
        beats.delete();
        access(1'b0, 1'b1, 32'h84, 32'hDEAD_BEEF, ld, cyc);
        check("whit_cycles", cyc, 32'd0);
        access(1'b1, 1'b0, 32'h84, 32'd0, ld, cyc);
        check("rhit_cycles", cyc, 32'd0);
        check("rhit_load", ld, 32'hDEAD_BEEF);
        check("hit_no_traffic", beats.size(), 32'd0);

        // LRU: 0x80, 0x180, 0x80, then 0x280 evicts clean 0x180
        access(1'b1, 1'b0, 32'h180, 32'd0, ld, cyc);
        check("r180_load", ld, 32'hF000_0180);
        check("r180_cycles", cyc, 32'd3);
        access(1'b1, 1'b0, 32'h80, 32'd0, ld, cyc);
        check("r80_cycles", cyc, 32'd0);
        beats.delete();
        access(1'b1, 1'b0, 32'h280, 32'd0, ld, cyc);
        check("r280_load", ld, 32'hF000_0280);
        check("r280_cycles", cyc, 32'd3);
        check("r280_nbeats", beats.size(), 32'd2);
        check_beat(0, 1'b0, 32'h280, 32'hF000_0280);
        access(1'b1, 1'b0, 32'h80, 32'd0, ld, cyc);
        check("r80_kept_cycles", cyc, 32'd0);
        check("r80_kept_load", ld, 32'hAAAA_0000);

        // dirty 0x280, then 0x380 evicts dirty 0x80 block with slow memory
        access(1'b0, 1'b1, 32'h280, 32'h5555_AAAA, ld, cyc);
        check("w280_cycles", cyc, 32'd0);
        lat = 3;
        beats.delete();
        access(1'b1, 1'b0, 32'h380, 32'd0, ld, cyc);
        check("wb_cycles", cyc, 32'd17);
        check("wb_load", ld, 32'hF000_0380);
        check("wb_nbeats", beats.size(), 32'd4);
        check_beat(0, 1'b1, 32'h80, 32'hAAAA_0000);
        check_beat(1, 1'b1, 32'h84, 32'hDEAD_BEEF);
        check_beat(2, 1'b0, 32'h380, 32'hF000_0380);
        check_beat(3, 1'b0, 32'h384, 32'hF000_0384);
        check("wb_stable", unstable, 32'd0);
        lat = 0;

        // two more dirty blocks: way0 set1 and way0 set2
        access(1'b0, 1'b1, 32'h388, 32'h0BAD_0388, ld, cyc);
        check("w388_cycles", cyc, 32'd3);
        access(1'b0, 1'b1, 32'h90, 32'h0BAD_0090, ld, cyc);
        check("w90_cycles", cyc, 32'd3);

        // flush
        beats.delete();
        @(posedge clk);
        #1;
        halt = 1'b1;
        n = 0;
        while (!flushed && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("flushed", {31'd0, flushed}, 32'd1);
        check("flush_dhit", {31'd0, dhit}, 32'd0);
`ifdef HITCOUNT_EN
        check("flush_nbeats", beats.size(), 32'd7);
        check_beat(6, 1'b1, 32'h3100, 32'd5);
`else
        check("flush_nbeats", beats.size(), 32'd6);
`endif
        check_beat(0, 1'b1, 32'h388, 32'h0BAD_0388);
        check_beat(1, 1'b1, 32'h38C, 32'hF000_038C);
        check_beat(2, 1'b1, 32'h90, 32'h0BAD_0090);
        check_beat(3, 1'b1, 32'h94, 32'hF000_0094);
        check_beat(4, 1'b1, 32'h280, 32'h5555_AAAA);
        check_beat(5, 1'b1, 32'h284, 32'hF000_0284);
        repeat (3) @(posedge clk);
        #2;
        check("flushed_held", {31'd0, flushed}, 32'd1);
        check("flushed_dWEN", {31'd0, dWEN}, 32'd0);

        // reset during the second fetch beat
        @(posedge clk);
        #1;
        nRST = 1'b0;
        halt = 1'b0;
        #2;
        check("rst2_flushed", {31'd0, flushed}, 32'd0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        lat = 2;
        @(posedge clk);
        #1;
        dmemREN = 1'b1;
        dmemaddr = 32'h84;
        n = 0;
        while (!(dREN && daddr == 32'h84) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mid_daddr", daddr, 32'h84);
        #1;
        nRST = 1'b0;
        #1;
        check("mid_dREN", {31'd0, dREN}, 32'd0);
        check("mid_dWEN", {31'd0, dWEN}, 32'd0);
        check("mid_daddr0", daddr, 32'd0);
        check("mid_dhit", {31'd0, dhit}, 32'd0);
        dmemREN = 1'b0;
        @(posedge clk);
        #1;
        nRST = 1'b1;
        lat = 0;
        beats.delete();
        access(1'b1, 1'b0, 32'h84, 32'd0, ld, cyc);
        check("post_rst_cycles", cyc, 32'd3);
        check("post_rst_load", ld, 32'hDEAD_BEEF);
        check_beat(0, 1'b0, 32'h80, 32'hAAAA_0000);

        check("never_both", both, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
